// File: rtl/sr165_scanner.sv
// sr165_scanner: scans a 74LV165-style chain, assembles an NBITS frame and debounces it over DEBOUNCE scans
module sr165_scanner #(
  parameter int NBITS = 16,
  parameter int DEBOUNCE = 3,
  parameter logic [NBITS-1:0] INIT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic             sr_data,
  output logic             sr_clk,
  output logic             sr_load_n,
  output logic [NBITS-1:0] frame,
  output logic             frame_valid,
  output logic             changed,
  output logic [NBITS-1:0] change_mask
);
  localparam int BW = $clog2(NBITS + 1);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [BW-1:0] LAST = BW'(NBITS - 1);
  localparam logic [SW-1:0] DB = SW'(DEBOUNCE);
  typedef enum logic [2:0] {IDLE, LOAD, LATCH, SHIFT_LO, SHIFT_HI, DONE} state_t;
  state_t state;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] stable, stable_nx;
  logic [NBITS-1:0] sr, prev;
  logic same;
  assign same = sr == prev;
  assign stable_nx = !same ? SW'(1) : stable == DB ? stable : stable + 1'b1;
  // the last SHIFT_HI tick already holds the full raw frame, so results land as the FSM enters DONE
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sr_clk <= 1'b0;
      sr_load_n <= 1'b1;
      frame <= INIT;
      prev <= INIT;
      frame_valid <= 1'b0;
      changed <= 1'b0;
      change_mask <= '0;
      stable <= '0;
      bit_cnt <= '0;
      sr <= '0;
    end else begin
      frame_valid <= 1'b0;
      changed <= 1'b0;
      if (clken)
        case (state)
          IDLE, DONE: begin
            sr_load_n <= 1'b0;
            state <= LOAD;
          end
          LOAD: begin
            sr_load_n <= 1'b1;
            bit_cnt <= '0;
            state <= LATCH;
          end
          LATCH: state <= SHIFT_LO;
          SHIFT_LO: begin
            sr <= (sr << 1) | NBITS'(sr_data);
            sr_clk <= 1'b1;
            state <= SHIFT_HI;
          end
          SHIFT_HI: begin
            sr_clk <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            state <= bit_cnt == LAST ? DONE : SHIFT_LO;
            if (bit_cnt == LAST) begin
              frame_valid <= 1'b1;
              stable <= stable_nx;
              if (!same) prev <= sr;
              if (stable_nx == DB && sr != frame) begin
                frame <= sr;
                change_mask <= frame ^ sr;
                changed <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
    end
endmodule
